// File: rtl/run_len_detector.sv
// rtl/run_len_detector.sv - detects RUN_LEN consecutive equal bits on a gated serial input
//
// Purpose:
//   Samples serial bit w on rising clk edges where en=1 and raises z (registered,
//   Moore) once RUN_LEN consecutive identical bits have been seen, for either polarity.
//   restart_mode selects overlapping (z holds while the run continues) or
//   non-overlapping blocks (each detection needs a fresh block of RUN_LEN bits).
//
// Ports:
//   clk           in   1      rising-edge clock
//   aclr          in   1      asynchronous active-low reset
//   en            in   1      sample strobe; all registers hold when 0
//   w             in   1      serial data bit
//   restart_mode  in   1      0 = saturate/overlap, 1 = non-overlapping blocks
//   z             out  1      run detected
//   run_len       out  CNT_W  length of current run, saturates at RUN_LEN
//   run_val       out  1      bit value of current run
//   evt_cnt       out  EVT_W  detections since reset, wraps silently
//   state         out  2      0 IDLE, 1 RUN, 2 HIT

module run_len_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = $clog2(RUN_LEN + 1),
    parameter int EVT_W   = 8
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             en,
    input  logic             w,
    input  logic             restart_mode,
    output logic             z,
    output logic [CNT_W-1:0] run_len,
    output logic             run_val,
    output logic [EVT_W-1:0] evt_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        BAD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(RUN_LEN);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] len_q, len_n;
    logic             val_q, val_n;
    logic [EVT_W-1:0] cnt_q, cnt_n;
    logic             z_q, z_n;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= IDLE;
            len_q   <= '0;
            val_q   <= 1'b0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_n;
            len_q   <= len_n;
            val_q   <= val_n;
            cnt_q   <= cnt_n;
            z_q     <= z_n;
        end
    end

    always_comb begin
        state_n = state_q;
        len_n   = len_q;
        val_n   = val_q;
        cnt_n   = cnt_q;
        z_n     = z_q;
        if (en) begin
            case (state_q)
                RUN: begin
                    if (w == val_q) begin
                        // In RUN the length is at most RUN_LEN-1, so +1 cannot overflow.
                        len_n = len_q + LEN_ONE;
                        if (len_n == LEN_MAX) begin
                            state_n = HIT;
                            cnt_n   = cnt_q + EVT_W'(1);
                        end
                    end else begin
                        len_n = LEN_ONE;
                        val_n = w;
                    end
                end
                HIT: begin
                    if (w != val_q) begin
                        state_n = RUN;
                        len_n   = LEN_ONE;
                        val_n   = w;
                    end else if (restart_mode) begin
                        // Current bit starts the next non-overlapping block.
                        state_n = RUN;
                        len_n   = LEN_ONE;
                    end
                end
                default: begin
                    // IDLE, and recovery from the unused encoding.
                    state_n = RUN;
                    len_n   = LEN_ONE;
                    val_n   = w;
                end
            endcase
            z_n = (state_n == HIT);
        end
    end

    assign z       = z_q;
    assign run_len = len_q;
    assign run_val = val_q;
    assign evt_cnt = cnt_q;
    assign state   = state_q;

endmodule
